// File: rtl/gsram_dp.sv
// Dual-port synchronous SRAM with self-clearing INIT sequence, per-bit write masks and collision flag.
// Optional same-address read/write forwarding is enabled by defining GSRAM_DP_BYPASS_EN.
module gsram_dp #(
    parameter int ABITS  = 11,
    parameter int DBITS  = 8,
    parameter int OUTREG = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [ABITS-1:0] A0,
    input  logic [ABITS-1:0] A1,
    input  logic [DBITS-1:0] D0,
    input  logic [DBITS-1:0] D1,
    output logic [DBITS-1:0] Q0,
    output logic [DBITS-1:0] Q1,
    input  logic             WE0,
    input  logic             WE1,
    input  logic [DBITS-1:0] WEM0,
    input  logic [DBITS-1:0] WEM1,
    input  logic             CE0,
    input  logic             CE1,
    output logic             READY,
    output logic             COLL,
    output logic             dbg_state
);

    localparam int DEPTH = 1 << ABITS;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [ABITS-1:0] cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic             coll_q, coll_d;
    logic [DBITS-1:0] mem_q [0:DEPTH-1];

    logic             run, wr0, wr1, rd0, rd1, same_addr;
    logic [DBITS-1:0] w0_word, w1_word, r0_word, r1_word;
    logic [DBITS-1:0] q0_q, q1_q;

    always_comb begin
        run       = (state_q == ST_RUN);
        wr0       = run & CE0 & WE0;
        wr1       = run & CE1 & WE1;
        rd0       = run & CE0 & ~WE0;
        rd1       = run & CE1 & ~WE1;
        same_addr = (A0 == A1);

        // Port 1 merges first so port 0 overrides it on bits both ports mask in.
        w1_word = (mem_q[A1] & ~WEM1) | (D1 & WEM1);
        w0_word = (((wr1 && same_addr) ? w1_word : mem_q[A0]) & ~WEM0) | (D0 & WEM0);

        r0_word = mem_q[A0];
        r1_word = mem_q[A1];
`ifdef GSRAM_DP_BYPASS_EN
        if (wr1 && same_addr) r0_word = w1_word;
        if (wr0 && same_addr) r1_word = w0_word;
`endif

        coll_d = wr0 & wr1 & same_addr & (|(WEM0 & WEM1));

        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == {ABITS{1'b1}}) state_d = ST_RUN;
        end
        ready_d = (state_d == ST_RUN);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            coll_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            coll_q  <= coll_d;
        end
    end

    // Storage has no reset; the INIT walk is what clears it.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (state_q == ST_INIT) begin
                mem_q[cnt_q] <= '0;
            end else begin
                if (wr1) mem_q[A1] <= w1_word;
                if (wr0) mem_q[A0] <= w0_word;
            end
        end
    end

    generate
        if (OUTREG != 0) begin : g_oreg
            logic [DBITS-1:0] s0_q, s0_d, s1_q, s1_d, q0_d, q1_d;
            logic             v0_q, v1_q;

            always_comb begin
                s0_d = rd0 ? r0_word : s0_q;
                s1_d = rd1 ? r1_word : s1_q;
                q0_d = v0_q ? s0_q : q0_q;
                q1_d = v1_q ? s1_q : q1_q;
            end

            always_ff @(posedge CLK) begin
                if (RST) begin
                    s0_q <= '0;
                    s1_q <= '0;
                    v0_q <= 1'b0;
                    v1_q <= 1'b0;
                    q0_q <= '0;
                    q1_q <= '0;
                end else begin
                    s0_q <= s0_d;
                    s1_q <= s1_d;
                    v0_q <= rd0;
                    v1_q <= rd1;
                    q0_q <= q0_d;
                    q1_q <= q1_d;
                end
            end
        end else begin : g_noreg
            logic [DBITS-1:0] q0_d, q1_d;

            always_comb begin
                q0_d = rd0 ? r0_word : q0_q;
                q1_d = rd1 ? r1_word : q1_q;
            end

            always_ff @(posedge CLK) begin
                if (RST) begin
                    q0_q <= '0;
                    q1_q <= '0;
                end else begin
                    q0_q <= q0_d;
                    q1_q <= q1_d;
                end
            end
        end
    endgenerate

    assign Q0        = q0_q;
    assign Q1        = q1_q;
    assign READY     = ready_q;
    assign COLL      = coll_q;
    assign dbg_state = state_q;

endmodule
